// File: rtl/pc_unit.sv
// Program-counter unit with a circular return-address stack for the fetch stage.
// Optional PC_TRACE_EN macro compiles in a simulation trace of resets, PC updates and RAS faults.
module pc_unit #(
   parameter int               WIDTH      = 32,
   parameter int               STEP       = 4,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0,
   parameter int               RAS_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_offset,
   input  logic             jump,
   input  logic             call,
   input  logic             ret,
   input  logic [WIDTH-1:0] jump_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus_step,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_overflow,
   output logic             ras_underflow
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [WIDTH-1:0] ras_d [RAS_DEPTH];

   assign pc            = pc_q;
   assign pc_plus_step  = pc_q + WIDTH'(STEP);
   assign ras_empty     = (cnt_q == '0);
   assign ras_full      = (cnt_q == CNT_W'(RAS_DEPTH));
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pc_d  = pc_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      push  = 1'b0;
      if (!stall) begin
         if (ret) begin
            if (!ras_empty) begin
               pc_d  = ras_q[ptr_q];
               ptr_d = ptr_q - PTR_W'(1);
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               pc_d  = pc_plus_step;
               unf_d = 1'b1;
            end
         end else if (call) begin
            pc_d  = jump_target;
            ptr_d = ptr_q + PTR_W'(1);
            push  = 1'b1;
            // A full stack wraps onto its oldest entry rather than refusing the push.
            if (ras_full) ovf_d = 1'b1;
            else          cnt_d = cnt_q + CNT_W'(1);
         end else if (jump) begin
            pc_d = jump_target;
         end else if (branch_taken) begin
            pc_d = pc_q + branch_offset;
         end else begin
            pc_d = pc_plus_step;
         end
      end
   end

   always_comb begin
      ras_d = ras_q;
      if (push) ras_d[ptr_d] = pc_plus_step;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_ADDR;
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // NOTE: RAS storage is not reset; count and pointer alone define what is valid.
   always_ff @(posedge clk) begin
      ras_q <= ras_d;
   end

`ifdef PC_TRACE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         $display("@%0t: PC::RESET; PC is now %0h", $time, RESET_ADDR);
      end else if (!stall) begin
         if (ret && ras_empty) begin
            $display("@%0t: PC is now %0h (RET_EMPTY)", $time, pc_d);
            $display("@%0t: WARNING: RAS underflow", $time);
         end else if (ret) begin
            $display("@%0t: PC is now %0h (RET)", $time, pc_d);
         end else if (call) begin
            $display("@%0t: PC is now %0h (CALL)", $time, pc_d);
            if (ras_full) $display("@%0t: WARNING: RAS overflow", $time);
         end else if (jump) begin
            $display("@%0t: PC is now %0h (JMP)", $time, pc_d);
         end else if (branch_taken) begin
            $display("@%0t: PC is now %0h (BR)", $time, pc_d);
         end else begin
            $display("@%0t: PC is now %0h (SEQ)", $time, pc_d);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: a 32-bit instance for the main plan
// and an 8-bit instance for address wrap and reset-mid-call-chain.
module tb_pc_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // 32-bit instance
   logic        rst, stall, branch_taken, jump, call, ret;
   logic [31:0] branch_offset, jump_target;
   logic [31:0] pc, pc_plus_step;
   logic        ras_empty, ras_full, ras_overflow, ras_underflow;

   // 8-bit instance
   logic        rst8, stall8, branch_taken8, jump8, call8, ret8;
   logic [7:0]  branch_offset8, jump_target8;
   logic [7:0]  pc8, pc_plus_step8;
   logic        ras_empty8, ras_full8, ras_overflow8, ras_underflow8;

   pc_unit u_dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .call(call), .ret(ret),
      .jump_target(jump_target), .pc(pc), .pc_plus_step(pc_plus_step),
      .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   pc_unit #(.WIDTH(8), .STEP(4), .RESET_ADDR(8'h00), .RAS_DEPTH(4)) u_dut8 (
      .clk(clk), .rst(rst8), .stall(stall8), .branch_taken(branch_taken8),
      .branch_offset(branch_offset8), .jump(jump8), .call(call8), .ret(ret8),
      .jump_target(jump_target8), .pc(pc8), .pc_plus_step(pc_plus_step8),
      .ras_empty(ras_empty8), .ras_full(ras_full8),
      .ras_overflow(ras_overflow8), .ras_underflow(ras_underflow8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      call = 1'b0; ret = 1'b0; branch_offset = '0; jump_target = '0;
   endtask

   task automatic idle8();
      rst8 = 1'b0; stall8 = 1'b0; branch_taken8 = 1'b0; jump8 = 1'b0;
      call8 = 1'b0; ret8 = 1'b0; branch_offset8 = '0; jump_target8 = '0;
   endtask

   initial begin
      idle(); idle8();
      rst = 1'b1; rst8 = 1'b1;

      // 1: reset for two edges, then sequential
      step(); check("rst_pc0", pc, 32'h0);
      step(); check("rst_pc1", pc, 32'h0);
      check("rst_empty", {31'b0, ras_empty}, 32'h1);
      check("rst_full", {31'b0, ras_full}, 32'h0);
      check("rst_ovf", {31'b0, ras_overflow}, 32'h0);
      check("rst_unf", {31'b0, ras_underflow}, 32'h0);
      rst = 1'b0; rst8 = 1'b0;
      step(); check("seq_4", pc, 32'h4);
      check("pps_8", pc_plus_step, 32'h8);
      step(); check("seq_8", pc, 32'h8);
      step(); check("seq_c", pc, 32'hC);
      step(); check("seq_10", pc, 32'h10);

      // 2: negative branch, stall hold, resume
      branch_taken = 1'b1; branch_offset = 32'hFFFF_FFF0;
      step(); check("br_neg", pc, 32'h0);
      idle(); stall = 1'b1;
      step(); check("stall_0", pc, 32'h0);
      step(); check("stall_1", pc, 32'h0);
      stall = 1'b0;
      step(); check("unstall", pc, 32'h4);

      // 3: call / return
      jump = 1'b1; jump_target = 32'h100;
      step(); check("jmp_100", pc, 32'h100);
      idle(); call = 1'b1; jump_target = 32'h400;
      step(); check("call_400", pc, 32'h400);
      check("call_nonempty", {31'b0, ras_empty}, 32'h0);
      idle();
      step(); step(); check("seq_408", pc, 32'h408);
      ret = 1'b1;
      step(); check("ret_104", pc, 32'h104);
      check("ret_empty", {31'b0, ras_empty}, 32'h1);

      // 4: nested calls, overflow, underflow
      idle(); jump = 1'b1; jump_target = 32'h0;
      step(); check("jmp_0", pc, 32'h0);
      idle(); call = 1'b1;
      jump_target = 32'h10; step();
      jump_target = 32'h20; step();
      jump_target = 32'h30; step();
      check("full_3", {31'b0, ras_full}, 32'h0);
      jump_target = 32'h40; step();
      check("full_4", {31'b0, ras_full}, 32'h1);
      check("ovf_4", {31'b0, ras_overflow}, 32'h0);
      jump_target = 32'h50; step();
      check("pc_50", pc, 32'h50);
      check("ovf_5", {31'b0, ras_overflow}, 32'h1);
      check("full_5", {31'b0, ras_full}, 32'h1);
      idle(); ret = 1'b1;
      step(); check("ret_44", pc, 32'h44);
      step(); check("ret_34", pc, 32'h34);
      step(); check("ret_24", pc, 32'h24);
      step(); check("ret_14", pc, 32'h14);
      check("ret4_empty", {31'b0, ras_empty}, 32'h1);
      check("unf_before", {31'b0, ras_underflow}, 32'h0);
      step(); check("ret_empty_pc", pc, 32'h18);
      check("unf_set", {31'b0, ras_underflow}, 32'h1);
      idle(); stall = 1'b1;
      step(); check("stall_keeps_ovf", {31'b0, ras_overflow}, 32'h1);
      check("stall_keeps_unf", {31'b0, ras_underflow}, 32'h1);

      // 5: ret beats call/jump/branch
      idle(); jump = 1'b1; jump_target = 32'h1FC;
      step();
      idle(); call = 1'b1; jump_target = 32'h300;
      step(); check("call_300", pc, 32'h300);
      ret = 1'b1; call = 1'b1; jump = 1'b1; branch_taken = 1'b1;
      jump_target = 32'h999; branch_offset = 32'h40;
      step(); check("prio_ret_pc", pc, 32'h200);
      check("prio_no_push", {31'b0, ras_empty}, 32'h1);

      // 32-bit wrap of pc and pc_plus_step
      idle(); jump = 1'b1; jump_target = 32'hFFFF_FFFC;
      step(); check("pps_wrap", pc_plus_step, 32'h0);
      idle();
      step(); check("pc_wrap", pc, 32'h0);

      // reset clears sticky flags
      rst = 1'b1;
      step(); check("rst2_ovf", {31'b0, ras_overflow}, 32'h0);
      check("rst2_unf", {31'b0, ras_underflow}, 32'h0);
      check("rst2_pc", pc, 32'h0);
      idle();

      // 6: WIDTH=8 wrap and reset mid call chain
      jump8 = 1'b1; jump_target8 = 8'hFC;
      step(); check("w8_pc_fc", {24'b0, pc8}, 32'hFC);
      check("w8_pps_wrap", {24'b0, pc_plus_step8}, 32'h0);
      idle8();
      step(); check("w8_wrap", {24'b0, pc8}, 32'h0);
      call8 = 1'b1; jump_target8 = 8'h20; step();
      jump_target8 = 8'h40; step();
      check("w8_call_pc", {24'b0, pc8}, 32'h40);
      check("w8_nonempty", {31'b0, ras_empty8}, 32'h0);
      idle8(); rst8 = 1'b1;
      step(); check("w8_rst_empty", {31'b0, ras_empty8}, 32'h1);
      idle8(); ret8 = 1'b1;
      step(); check("w8_ret_pc", {24'b0, pc8}, 32'h4);
      check("w8_unf", {31'b0, ras_underflow8}, 32'h1);
      idle8();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
